postprocess_writeback: RTL

Output-side counterpart of the 3x3 window preprocessor. It collects the filtered 8-bit pixels that the core produces, one per `core_en_i` cycle, into ping-pong row buffers. It then streams each completed output row to the memory controller over a valid/ready write port, with column and row addresses. It reports row and frame completion to the controller and applies backpressure when both row buffers are full.

---
 rtl/postprocess_writeback.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/postprocess_writeback.sv
`default_nettype none
// ============================================================================
// postprocess_writeback : ping-pong row buffers draining core pixels to memory.
// Optional `POSTPROC_FRAME_CNT_EN adds the row counter and frame_done_o.
// Revision: 1.0
// ============================================================================
module postprocess_writeback #(
    parameter int MAX_COL = 540,
    parameter int MAX_ROW = 540,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             core_en_i,
    input  logic [7:0]       core_data_i,
    output logic             core_ready_o,
    output logic             wr_valid_o,
    input  logic             wr_ready_i,
    output logic [7:0]       wr_data_o,
    output logic [CNT_W-1:0] wr_col_o,
    output logic [CNT_W-1:0] wr_row_o,
    output logic             row_done_o,
    output logic             frame_done_o,
    output logic             overflow_o
);
    localparam int OUT_COL = MAX_COL - 2;
    localparam int AW      = (OUT_COL > 1) ? $clog2(OUT_COL) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(OUT_COL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [2][OUT_COL];
    logic [1:0]       full_q, full_d;
    logic             fill_bank_q, fill_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] fill_col_q, fill_col_d;
    logic [CNT_W-1:0] rd_col_q, rd_col_d;
    logic             wr_valid_q, wr_valid_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [CNT_W-1:0] wr_col_q, wr_col_d;
    logic             row_done_q, row_done_d;
    logic             overflow_q, overflow_d;

    logic             w_fill_ok;
    logic             w_to_done;
    logic [CNT_W-1:0] w_rd_next;

    assign w_fill_ok = core_en_i && !full_q[fill_bank_q];
    assign w_to_done = (state_q == S_DRAIN) && wr_ready_i && (rd_col_q == LAST_COL);
    assign w_rd_next = rd_col_q + 1'b1;

    always_ff @(posedge clk) begin
        if (w_fill_ok) begin
            mem_q[fill_bank_q][fill_col_q[AW-1:0]] <= core_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        fill_bank_d = fill_bank_q;
        fill_col_d  = fill_col_q;
        rd_bank_d   = rd_bank_q;
        rd_col_d    = rd_col_q;
        wr_valid_d  = wr_valid_q;
        wr_data_d   = wr_data_q;
        wr_col_d    = wr_col_q;
        row_done_d  = 1'b0;
        overflow_d  = overflow_q | (core_en_i & full_q[fill_bank_q]);

        if (w_fill_ok) begin
            if (fill_col_q == LAST_COL) begin
                fill_col_d          = '0;
                full_d[fill_bank_q] = 1'b1;
                fill_bank_d         = ~fill_bank_q;
            end else begin
                fill_col_d = fill_col_q + 1'b1;
            end
        end

        // Fill and release never target the same bank: fill needs !full, release needs full.
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d    = S_DRAIN;
                    rd_col_d   = '0;
                    wr_valid_d = 1'b1;
                    wr_data_d  = mem_q[rd_bank_q][{AW{1'b0}}];
                    wr_col_d   = '0;
                end
            end
            S_DRAIN: begin
                if (w_to_done) begin
                    state_d    = S_DONE;
                    wr_valid_d = 1'b0;
                    row_done_d = 1'b1;
                end else if (wr_ready_i) begin
                    rd_col_d  = w_rd_next;
                    wr_data_d = mem_q[rd_bank_q][w_rd_next[AW-1:0]];
                    wr_col_d  = w_rd_next;
                end
            end
            S_DONE: begin
                state_d           = S_IDLE;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            full_q      <= '0;
            fill_bank_q <= 1'b0;
            fill_col_q  <= '0;
            rd_bank_q   <= 1'b0;
            rd_col_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= '0;
            wr_col_q    <= '0;
            row_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            fill_bank_q <= fill_bank_d;
            fill_col_q  <= fill_col_d;
            rd_bank_q   <= rd_bank_d;
            rd_col_q    <= rd_col_d;
            wr_valid_q  <= wr_valid_d;
            wr_data_q   <= wr_data_d;
            wr_col_q    <= wr_col_d;
            row_done_q  <= row_done_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef POSTPROC_FRAME_CNT_EN
    localparam int OUT_ROW = MAX_ROW - 2;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(OUT_ROW - 1);

    logic [CNT_W-1:0] row_q, row_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (state_q == S_DONE) begin
            row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end
        if (w_to_done) begin
            frame_done_d = (row_q == LAST_ROW);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_row_o     = row_q;
    assign frame_done_o = frame_done_q;
`else
    assign wr_row_o     = '0;
    assign frame_done_o = 1'b0;
`endif

    assign core_ready_o = ~full_q[fill_bank_q];
    assign wr_valid_o   = wr_valid_q;
    assign wr_data_o    = wr_data_q;
    assign wr_col_o     = wr_col_q;
    assign row_done_o   = row_done_q;
    assign overflow_o   = overflow_q;

endmodule
`default_nettype wire
